// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two-requester register-file writeback arbiter with a one-entry output stage
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   flush                   drop staged write and current requests this cycle
//   req0_* (valid/addr/data/ready)  requester 0, ALU writeback
//   req1_* (valid/addr/data/ready)  requester 1, load writeback
//   rf_we/rf_waddr/rf_wdata register-file write port, one cycle after acceptance
//   conflict_cnt            saturating count of cycles with both requests valid
//   fwd_addr_a/b, fwd_hit_a/b, fwd_data_a/b  forwarding lookup of the staged write
//
// Optional feature: define RF_WB_FORWARD_EN to enable forwarding; otherwise the
// fwd_* outputs are tied to 0 and fwd_addr_* are ignored.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req0_valid,
    input  logic [4:0]  req0_addr,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [15:0] conflict_cnt,
    input  logic [4:0]  fwd_addr_a,
    input  logic [4:0]  fwd_addr_b,
    output logic        fwd_hit_a,
    output logic        fwd_hit_b,
    output logic [31:0] fwd_data_a,
    output logic [31:0] fwd_data_b
);
    typedef enum logic {PRI0 = 1'b0, PRI1 = 1'b1} pri_e;

    pri_e        state_q, state_d;
    logic        we_q, we_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] cnt_q, cnt_d;
    logic        gnt0, gnt1;

    always_comb begin
        // rst_n gates the grants so nothing is accepted while reset is held
        gnt0    = rst_n && !flush && req0_valid && (!req1_valid || state_q == PRI0);
        gnt1    = rst_n && !flush && req1_valid && (!req0_valid || state_q == PRI1);
        state_d = gnt0 ? PRI1 : gnt1 ? PRI0 : state_q;
        // x0 writes are accepted but never reach the register file
        we_d    = gnt0 ? (req0_addr != 5'd0) : gnt1 ? (req1_addr != 5'd0) : 1'b0;
        waddr_d = gnt0 ? req0_addr : gnt1 ? req1_addr : waddr_q;
        wdata_d = gnt0 ? req0_data : gnt1 ? req1_data : wdata_q;
        cnt_d   = (req0_valid && req1_valid && !flush && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PRI0;
            we_q    <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= 32'd0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req0_ready   = gnt0;
    assign req1_ready   = gnt1;
    assign rf_we        = we_q;
    assign rf_waddr     = waddr_q;
    assign rf_wdata     = wdata_q;
    assign conflict_cnt = cnt_q;

`ifdef RF_WB_FORWARD_EN
    assign fwd_hit_a  = we_q && fwd_addr_a == waddr_q && fwd_addr_a != 5'd0;
    assign fwd_hit_b  = we_q && fwd_addr_b == waddr_q && fwd_addr_b != 5'd0;
    assign fwd_data_a = fwd_hit_a ? wdata_q : 32'd0;
    assign fwd_data_b = fwd_hit_b ? wdata_q : 32'd0;
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_addr_a, fwd_addr_b};
    assign fwd_hit_a  = 1'b0;
    assign fwd_hit_b  = 1'b0;
    assign fwd_data_a = 32'd0;
    assign fwd_data_b = 32'd0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [4:0]  req0_addr, req1_addr, rf_waddr, fwd_addr_a, fwd_addr_b;
    logic [31:0] req0_data, req1_data, rf_wdata, fwd_data_a, fwd_data_b;
    logic        rf_we, fwd_hit_a, fwd_hit_b;
    logic [15:0] conflict_cnt;
    int          n_checks = 0;
    int          n_errors = 0;

    regfile_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .conflict_cnt(conflict_cnt),
        .fwd_addr_a(fwd_addr_a), .fwd_addr_b(fwd_addr_b), .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
        .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        fwd_addr_a = 5'd0;
        fwd_addr_b = 5'd0;
        drive(1'b1, 5'd5, 32'h1, 1'b1, 5'd6, 32'h2);
        #3;
        check("rst_we", {31'd0, rf_we}, 32'd0);
        check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_cnt", {16'd0, conflict_cnt}, 32'd0);
        check("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        // single request
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        #1;
        check("single_ready", {30'd0, req0_ready, req1_ready}, 32'd2);
        tick();
        idle();
        check("single_we", {31'd0, rf_we}, 32'd1);
        check("single_waddr", {27'd0, rf_waddr}, 32'd5);
        check("single_wdata", rf_wdata, 32'hDEADBEEF);
        tick();
        check("single_we_drop", {31'd0, rf_we}, 32'd0);
        check("single_waddr_hold", {27'd0, rf_waddr}, 32'd5);
        // contention from fresh reset
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd2, 32'h200);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("cont_ready", {30'd0, req0_ready, req1_ready}, (i % 2 == 0) ? 32'd2 : 32'd1);
            tick();
            check("cont_waddr", {27'd0, rf_waddr}, (i % 2 == 0) ? 32'd1 : 32'd2);
            check("cont_wdata", rf_wdata, (i % 2 == 0) ? 32'h100 : 32'h200);
        end
        idle();
        check("cont_cnt", {16'd0, conflict_cnt}, 32'd4);
        // x0 suppression: put FSM in PRI1 first
        drive(1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'd0);
        tick();
        check("x0_pre_we", {31'd0, rf_we}, 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
        #1;
        check("x0_ready", {30'd0, req0_ready, req1_ready}, 32'd1);
        tick();
        check("x0_we", {31'd0, rf_we}, 32'd0);
        drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd2, 32'h200);
        #1;
        check("x0_fsm_pri0", {30'd0, req0_ready, req1_ready}, 32'd2);
        tick();
        check("x0_post_we", {31'd0, rf_we}, 32'd1);
        check("x0_post_cnt", {16'd0, conflict_cnt}, 32'd5);
        // flush with FSM in PRI1 and a write staged
        flush = 1'b1;
        #1;
        check("flush_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        tick();
        check("flush_we", {31'd0, rf_we}, 32'd0);
        check("flush_cnt", {16'd0, conflict_cnt}, 32'd5);
        flush = 1'b0;
        #1;
        check("flush_fsm_kept", {30'd0, req0_ready, req1_ready}, 32'd1);
        tick();
        check("after_flush_we", {31'd0, rf_we}, 32'd1);
        check("after_flush_waddr", {27'd0, rf_waddr}, 32'd2);
        check("after_flush_cnt", {16'd0, conflict_cnt}, 32'd6);
        // forwarding lookup
        drive(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0);
        tick();
        idle();
        fwd_addr_a = 5'd7;
        fwd_addr_b = 5'd8;
        #1;
`ifdef RF_WB_FORWARD_EN
        check("fwd_hit_a", {31'd0, fwd_hit_a}, 32'd1);
        check("fwd_data_a", fwd_data_a, 32'hA5A5A5A5);
`else
        check("fwd_hit_a", {31'd0, fwd_hit_a}, 32'd0);
        check("fwd_data_a", fwd_data_a, 32'd0);
`endif
        check("fwd_hit_b", {31'd0, fwd_hit_b}, 32'd0);
        check("fwd_data_b", fwd_data_b, 32'd0);
        // async reset mid-stream while rf_we is 1 and FSM is PRI1
        check("pre_async_we", {31'd0, rf_we}, 32'd1);
        drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd2, 32'h200);
        #1 rst_n = 1'b0;
        #1;
        check("async_we", {31'd0, rf_we}, 32'd0);
        check("async_waddr", {27'd0, rf_waddr}, 32'd0);
        check("async_wdata", rf_wdata, 32'd0);
        check("async_cnt", {16'd0, conflict_cnt}, 32'd0);
        check("async_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("async_fsm_pri0", {30'd0, req0_ready, req1_ready}, 32'd2);
        tick();
        idle();
        check("async_post_cnt", {16'd0, conflict_cnt}, 32'd1);
        check("async_post_waddr", {27'd0, rf_waddr}, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
